// File: rtl/box_downsample.sv
// box_downsample: averages each DX x DY block of 8-bit luma pixels into one
// output pixel and stores the result in an on-chip frame buffer. The buffer
// is read through a registered random-access port.
// Optional feature: define BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN to select a double-buffered frame store.
// Without it, a single bank is used and reads can observe a frame while it is being written.
module box_downsample #(
    parameter int unsigned LOG2_PPC = 2,
    parameter int unsigned LOG2_DX  = 4,
    parameter int unsigned LOG2_DY  = 4,
    parameter int unsigned OUT_W    = 40,
    parameter int unsigned OUT_H    = 30,
    localparam int unsigned PPC     = 1 << LOG2_PPC,
    localparam int unsigned XW      = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int unsigned YW      = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               in_frame,
    input  logic               in_line,
    input  logic               data_enable,
    input  logic [8*PPC-1:0]   pixel_data,
    input  logic [XW-1:0]      read_x,
    input  logic [YW-1:0]      read_y,
    output logic [7:0]         read_q,
    output logic               frame_done
);

    localparam int unsigned DY    = 1 << LOG2_DY;
    localparam int unsigned SHIFT = LOG2_DX + LOG2_DY;
    localparam int unsigned WSW   = 8 + LOG2_PPC;
    localparam int unsigned GW    = 8 + LOG2_DX;
    localparam int unsigned AW    = 8 + SHIFT;
    localparam int unsigned WPG   = 1 << (LOG2_DX - LOG2_PPC);
    localparam int unsigned WCW   = (LOG2_DX > LOG2_PPC) ? (LOG2_DX - LOG2_PPC) : 1;
    localparam int unsigned CW    = $clog2(OUT_W + 1);
    localparam int unsigned LMAX  = OUT_H * DY;
    localparam int unsigned LW    = $clog2(LMAX + 1);
    localparam int unsigned NPIX  = OUT_W * OUT_H;
`ifdef BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif
    localparam int unsigned MEM_N = NPIX * NBANK;
    localparam int unsigned MAW   = (MEM_N > 1) ? $clog2(MEM_N) : 1;

    logic            frame_prev_q, frame_prev_d;
    logic            armed_q, armed_d;
    logic            line_prev_q, line_prev_d;
    logic [LW-1:0]   line_q, line_d;
    logic [CW-1:0]   col_q, col_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [GW-1:0]   hacc_q, hacc_d;
    logic [AW-1:0]   colacc_q [OUT_W];
    logic [AW-1:0]   colacc_d [OUT_W];
    logic            done_q, done_d;
    logic [7:0]      read_d;
`ifdef BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN
    logic            bank_q, bank_d;
`endif

    logic [7:0]      buf_mem [MEM_N];

    logic [WSW-1:0]  word_sum;
    logic [GW-1:0]   group_sum;
    logic [XW-1:0]   col_idx;
    logic [LW-1:0]   row_idx;
    logic            band_first;
    logic            band_last;
    logic [AW-1:0]   entry_base;
    logic [AW-1:0]   entry_sum;
    logic            accept;
    logic            wr_en;
    logic [MAW-1:0]  wr_addr;
    logic [7:0]      wr_data;
    logic [MAW-1:0]  wr_off;
    logic [MAW-1:0]  rd_off;
    logic [MAW-1:0]  rd_addr;
    logic            rd_ok;

    // Next-state: accumulation, line/column tracking, buffer write and read address
    always_comb begin
        frame_prev_d = in_frame;
        line_prev_d  = in_line;
        armed_d      = in_frame && (armed_q || !frame_prev_q);
        line_d       = line_q;
        col_d        = col_q;
        wcnt_d       = wcnt_q;
        hacc_d       = hacc_q;
        colacc_d     = colacc_q;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;

`ifdef BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN
        wr_off = bank_q ? MAW'(0) : MAW'(NPIX);
        rd_off = bank_q ? MAW'(NPIX) : MAW'(0);
`else
        wr_off = MAW'(0);
        rd_off = MAW'(0);
`endif

        word_sum = '0;
        for (int i = 0; i < int'(PPC); i++) begin
            word_sum = word_sum + WSW'(pixel_data[8*i +: 8]);
        end
        group_sum  = hacc_q + GW'(word_sum);
        col_idx    = XW'(col_q);
        row_idx    = line_q >> LOG2_DY;
        band_first = (line_q & LW'(DY - 1)) == '0;
        band_last  = (line_q & LW'(DY - 1)) == LW'(DY - 1);
        entry_base = band_first ? '0 : colacc_q[col_idx];
        entry_sum  = entry_base + AW'(group_sum);
        wr_addr    = MAW'(row_idx) * MAW'(OUT_W) + MAW'(col_idx) + wr_off;

        accept = armed_d && in_line && data_enable &&
                 (col_q < CW'(OUT_W)) && (line_q < LW'(LMAX));

        if (!armed_d) begin
            line_d = '0;
            col_d  = '0;
            wcnt_d = '0;
            hacc_d = '0;
        end else if (line_prev_q && !in_line) begin
            if (line_q < LW'(LMAX)) begin
                line_d = line_q + LW'(1);
            end
            col_d  = '0;
            wcnt_d = '0;
            hacc_d = '0;
        end else if (accept) begin
            if (32'(wcnt_q) == WPG - 1) begin
                wcnt_d = '0;
                hacc_d = '0;
                col_d  = col_q + CW'(1);
                if (band_last) begin
                    wr_en   = 1'b1;
                    wr_data = 8'(entry_sum >> SHIFT);
                    done_d  = (32'(row_idx) == OUT_H - 1) && (32'(col_q) == OUT_W - 1);
                end else begin
                    colacc_d[col_idx] = entry_sum;
                end
            end else begin
                wcnt_d = wcnt_q + WCW'(1);
                hacc_d = group_sum;
            end
        end

`ifdef BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN
        bank_d = bank_q ^ done_d;
`endif

        rd_ok   = (32'(read_x) < OUT_W) && (32'(read_y) < OUT_H);
        rd_addr = MAW'(read_y) * MAW'(OUT_W) + MAW'(read_x) + rd_off;
        read_d  = rd_ok ? buf_mem[rd_addr] : 8'h00;
    end

    // State registers
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            frame_prev_q <= 1'b1;
            armed_q      <= 1'b0;
            line_prev_q  <= 1'b0;
            line_q       <= '0;
            col_q        <= '0;
            wcnt_q       <= '0;
            hacc_q       <= '0;
            colacc_q     <= '{default: '0};
            done_q       <= 1'b0;
            read_q       <= 8'h00;
`ifdef BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN
            bank_q       <= 1'b0;
`endif
        end else begin
            frame_prev_q <= frame_prev_d;
            armed_q      <= armed_d;
            line_prev_q  <= line_prev_d;
            line_q       <= line_d;
            col_q        <= col_d;
            wcnt_q       <= wcnt_d;
            hacc_q       <= hacc_d;
            colacc_q     <= colacc_d;
            done_q       <= done_d;
            read_q       <= read_d;
`ifdef BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN
            bank_q       <= bank_d;
`endif
        end
    end

    // Frame buffer storage, not reset
    always_ff @(posedge pixel_clock) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= wr_data;
        end
    end

    assign frame_done = done_q;

endmodule

// File: doc/box_downsample.md
# box_downsample

Parametrised 2D box-filter downsampler for the CSI-2 receive video path. It sits after the pixel unpacker on the pixel clock and averages every DX×DY block of 8-bit luma pixels, packed PPC pixels per word, into one output pixel. Results go to an on-chip frame buffer that the consumer logic reads through a registered random-access port. Unlike the single-row-sampling predecessor, every input line contributes to its block, and the factors and pixel packing are parameters.

## Interface
- `LOG2_PPC`, default 2: pixels per input word (PPC = 2^LOG2_PPC).
- `LOG2_DX`, default 4: horizontal factor DX = 2^LOG2_DX pixels; must be ≥ LOG2_PPC.
- `LOG2_DY`, default 4: vertical factor DY = 2^LOG2_DY lines.
- `OUT_W`, default 40: output columns.
- `OUT_H`, default 30: output rows.
- `pixel_clock` input, 1 bit: the only clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `in_frame` input, 1 bit: high for the duration of a frame.
- `in_line` input, 1 bit: high for the duration of a line.
- `data_enable` input, 1 bit: `pixel_data` is valid this cycle.
- `pixel_data` input, 8·PPC bits: PPC pixels, with the leftmost pixel in [7:0].
- `read_x` input, clog2(OUT_W) bits: read column.
- `read_y` input, clog2(OUT_H) bits: read row.
- `read_q` output, 8 bits: buffer data, one cycle after the address.
- `frame_done` output, 1 bit: one-cycle pulse when the final output pixel of a frame is written.

## Operation
- **Word sum:** on each accepted word (`in_frame && in_line && data_enable`), sum the PPC pixels.
- **Horizontal accumulator:** add the word sum into the horizontal accumulator. A group completes after DX/PPC words.
- **Column accumulator array:** OUT_W entries, each 8+LOG2_DX+LOG2_DY bits. Asynchronous read; written on group completion for column `col`:
  - first line of a band (`line % DY == 0`): entry ← group sum (clears the previous band);
  - middle lines: entry ← entry + group sum;
  - last line of a band: buffer[row·OUT_W+col] ← (entry + group sum) >> (LOG2_DX+LOG2_DY). Truncating, no rounding.
- **Line counter:** increments on the falling edge of `in_line` while `in_frame` is high. On the same edge, `col` and the horizontal accumulator clear; a partial group is discarded.
- **Out-of-range input:**
  - words with `col ≥ OUT_W` are ignored;
  - lines with `line ≥ OUT_H·DY` are ignored.
- **frame_done:** pulses in the cycle after the write of (row OUT_H-1, col OUT_W-1).
- **`in_frame` low:** line, col and horizontal accumulator are held at 0. A frame aborted mid-way produces no `frame_done`. Buffer writes already made remain.
- **Read port:** `read_q` ← buffer[read_y·OUT_W+read_x] each cycle. Out-of-range coordinates return 0x00.
- **Write/read collision:** a simultaneous write and read of the same address returns the old data.

## Timing
- **Reset values:** `read_q` = 0, `frame_done` = 0, all counters, accumulators and the bank select = 0. Buffer contents are not reset.
- **Reset mid-frame:** the block ignores input until the next rising edge of `in_frame`.
- **Throughput:** one word per cycle, back-to-back, including DX = PPC, where every word completes a group.
- **Write latency:** a buffer write occurs on the clock edge that accepts the group's last word.
- **frame_done latency:** asserted 1 cycle after that edge.
- **Read latency:** 1 cycle. `read_x`/`read_y` are free-running, with no handshake.

## Configuration
- `BOX_DOWNSAMPLE_DOUBLE_BUFFER_EN` defined:
  - two banks; writes go to the back bank, reads come from the front bank;
  - the banks swap on the cycle `frame_done` asserts;
  - reads never show a partially written frame;
  - an aborted frame does not swap.
- Macro undefined:
  - single bank;
  - reads see live writes, so tearing is possible.

## Test plan
- **Flat frame:** 640×480 frame of constant pixel 0x80, defaults -> all 1200 locations read 0x80; exactly one `frame_done` pulse, 1 cycle after the last word of line 479.
- **Horizontal ramp:** pixel = x mod 256 -> `read_q` at columns 0..15 = 16·x+7 on every row.
- **Vertical ramp:** pixel = line mod 256 -> rows 0..15 read 16·y+7 in every column. Checks band clear and accumulation.
- **Overlong frame:** 700-pixel lines and 500 lines -> identical results to the 640×480 case; no writes outside 40×30; one `frame_done`.
- **Abort and reset:**
  - `in_frame` dropped in band 10, then a full 0x40 frame -> all locations 0x40, one `frame_done`;
  - `reset` pulsed mid-frame -> `read_q` = 0, `frame_done` low.
- **Double buffer (macro on):** frame A = 0x10, then frame B = 0x90 -> reads return 0x10 throughout B until its `frame_done`, then 0x90. With the macro off, the location (0,0) read changes during B.
